// File: rtl/pipe_regfile_pkg.sv
// Shared register-file constants: widths, the "no register" index and the
// architectural register names used by decode, execute and hazard logic.
package pipe_regfile_pkg;

  localparam int XLEN = 64;
  localparam int AW = 4;
  localparam logic [AW-1:0] RNONE = 4'hF;
  localparam logic [AW-1:0] SP_IDX = 4'd4;

  typedef enum logic [AW-1:0] {
    RAX = 4'd0,
    RCX = 4'd1,
    RDX = 4'd2,
    RBX = 4'd3,
    RSP = 4'd4,
    RBP = 4'd5,
    RSI = 4'd6,
    RDI = 4'd7,
    R8  = 4'd8,
    R9  = 4'd9,
    R10 = 4'd10,
    R11 = 4'd11,
    R12 = 4'd12,
    R13 = 4'd13,
    R14 = 4'd14,
    NOREG = 4'd15
  } regIdx_e;

endpackage

// File: rtl/pipe_regfile_bypass.sv
// Per-read-port forwarding mux: the M port beats the E port, which beats the
// stored value, so a pending writeback is visible in the same cycle.
module regfile_bypass #(
  parameter int XLEN = 64,
  parameter int AW = 4,
  parameter logic [AW-1:0] RNONE = '1
) (
  input  logic [AW-1:0]   src,
  input  logic            wrEn,
  input  logic [AW-1:0]   dstE,
  input  logic [XLEN-1:0] valE,
  input  logic [AW-1:0]   dstM,
  input  logic [XLEN-1:0] valM,
  input  logic [XLEN-1:0] stored,
  output logic [XLEN-1:0] val
);

  always_comb begin
    val = stored;
    if (wrEn && src == dstM && dstM != RNONE) begin
      val = valM;
    end else if (wrEn && src == dstE && dstE != RNONE) begin
      val = valE;
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Two-read, two-write pipeline register file with writeback bypass, a debug
// read port that sees only committed state, and a same-index write flag.
module pipe_regfile #(
  parameter int XLEN = pipe_regfile_pkg::XLEN,
  parameter int AW = pipe_regfile_pkg::AW,
  parameter logic [AW-1:0] RNONE = pipe_regfile_pkg::RNONE,
  parameter logic [AW-1:0] SP_IDX = pipe_regfile_pkg::SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   srcA,
  input  logic [AW-1:0]   srcB,
  output logic [XLEN-1:0] valA,
  output logic [XLEN-1:0] valB,
  input  logic            wr_en,
  input  logic [AW-1:0]   dstE,
  input  logic [XLEN-1:0] valE,
  input  logic [AW-1:0]   dstM,
  input  logic [XLEN-1:0] valM,
  input  logic [AW-1:0]   dbg_idx,
  output logic [XLEN-1:0] dbg_val,
  output logic            wr_conflict
);
  import pipe_regfile_pkg::*;

  localparam int NREG = (2 ** AW) - 1;

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] storedA;
  logic [XLEN-1:0] storedB;
  logic            wrConflictReg;

  // One flop bank per register so every register can clear asynchronously.
  for (genvar gi = 0; gi < NREG; gi++) begin : gRegs
    localparam logic [AW-1:0] IDX = AW'(gi);
    localparam logic [XLEN-1:0] RST_VAL = (IDX == SP_IDX) ? SP_INIT : '0;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        regs[gi] <= RST_VAL;
      end else if (wr_en && dstM == IDX && dstM != RNONE) begin
        regs[gi] <= valM;
      end else if (wr_en && dstE == IDX && dstE != RNONE) begin
        regs[gi] <= valE;
      end
    end
  end

  // RNONE (and anything past the last register) has no storage and reads zero.
  always_comb begin
    storedA = '0;
    if (srcA != RNONE && int'(srcA) < NREG) storedA = regs[srcA];
  end

  always_comb begin
    storedB = '0;
    if (srcB != RNONE && int'(srcB) < NREG) storedB = regs[srcB];
  end

  always_comb begin
    dbg_val = '0;
    if (dbg_idx != RNONE && int'(dbg_idx) < NREG) dbg_val = regs[dbg_idx];
  end

  regfile_bypass #(.XLEN(XLEN), .AW(AW), .RNONE(RNONE)) bypassA (
    .src(srcA), .wrEn(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .stored(storedA), .val(valA)
  );

  regfile_bypass #(.XLEN(XLEN), .AW(AW), .RNONE(RNONE)) bypassB (
    .src(srcB), .wrEn(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .stored(storedB), .val(valB)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrConflictReg <= 1'b0;
    end else begin
      wrConflictReg <= wr_en && dstE == dstM && dstM != RNONE;
    end
  end

  assign wr_conflict = wrConflictReg;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: stimulus queues expected read values, a
// negedge monitor pops and compares them against the live outputs.
module tb_pipe_regfile;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [63:0] SPV = 64'h100;

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_DBG = 2;
  localparam int SEL_CONF = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  srcA = 4'hF;
  logic [3:0]  srcB = 4'hF;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        wr_en = 1'b0;
  logic [3:0]  dstE = 4'hF;
  logic [63:0] valE = '0;
  logic [3:0]  dstM = 4'hF;
  logic [63:0] valM = '0;
  logic [3:0]  dbg_idx = 4'hF;
  logic [63:0] dbg_val;
  logic        wr_conflict;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_regfile #(.SP_INIT(SPV)) dut (
    .clock(clock), .reset(reset),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .wr_en(wr_en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .dbg_idx(dbg_idx), .dbg_val(dbg_val), .wr_conflict(wr_conflict)
  );

  always #5 clock = ~clock;

  task automatic pushExp(input string name, input int sel, input logic [63:0] v);
    chk_t c;
    c.name = name;
    c.sel = sel;
    c.exp = v;
    sb.push_back(c);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    dstE = RNONE;
    dstM = RNONE;
    valE = '0;
    valM = '0;
  endtask

  // Monitor: everything queued during a cycle is compared at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        chk_t c;
        logic [63:0] act;
        c = sb.pop_front();
        case (c.sel)
          SEL_A:   act = valA;
          SEL_B:   act = valB;
          SEL_DBG: act = dbg_val;
          default: act = {63'd0, wr_conflict};
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end else begin
          $display("ok   %s: %h", c.name, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 1'b1;
    nextCycle();

    // Reset values, with a write pending while reset is still high.
    srcA = 4'd4; srcB = 4'd0; dbg_idx = 4'd3;
    pushExp("rst_valA_sp", SEL_A, SPV);
    pushExp("rst_valB_r0", SEL_B, 64'h0);
    pushExp("rst_dbg_r3", SEL_DBG, 64'h0);
    pushExp("rst_conflict", SEL_CONF, 64'h0);
    nextCycle();
    wr_en = 1'b1; dstE = 4'd1; valE = 64'h11; srcA = 4'd1; dbg_idx = 4'd1;
    pushExp("rst_bypass_valA", SEL_A, 64'h11);
    pushExp("rst_write_ignored", SEL_DBG, 64'h0);
    @(negedge clock);
    #1 reset = 1'b0;
    nextCycle();

    // First edge after release takes the pending write.
    idle(); srcA = 4'd4; dbg_idx = 4'd1;
    pushExp("release_write_r1", SEL_DBG, 64'h11);
    pushExp("release_sp", SEL_A, SPV);
    nextCycle();

    // Dual write to distinct registers, bypass on both ports.
    wr_en = 1'b1; dstE = 4'd2; valE = 64'hAA; dstM = 4'd3; valM = 64'hBB;
    srcA = 4'd2; srcB = 4'd3; dbg_idx = 4'd2;
    pushExp("dual_bypassE_valA", SEL_A, 64'hAA);
    pushExp("dual_bypassM_valB", SEL_B, 64'hBB);
    pushExp("dual_dbg_old_r2", SEL_DBG, 64'h0);
    nextCycle();
    idle(); dbg_idx = 4'd2; srcA = 4'd3;
    pushExp("dual_dbg_r2", SEL_DBG, 64'hAA);
    pushExp("dual_stored_valA_r3", SEL_A, 64'hBB);
    pushExp("dual_no_conflict", SEL_CONF, 64'h0);
    nextCycle();
    dbg_idx = 4'd3;
    pushExp("dual_dbg_r3", SEL_DBG, 64'hBB);
    nextCycle();

    // Same-index dual write: M wins, conflict pulses for one cycle.
    wr_en = 1'b1; dstE = 4'd4; valE = 64'h10; dstM = 4'd4; valM = 64'h20;
    srcA = 4'd4; srcB = 4'd4; dbg_idx = 4'd4;
    pushExp("same_bypass_valA", SEL_A, 64'h20);
    pushExp("same_bypass_valB", SEL_B, 64'h20);
    pushExp("same_dbg_old_sp", SEL_DBG, SPV);
    nextCycle();
    idle();
    pushExp("same_dbg_r4", SEL_DBG, 64'h20);
    pushExp("same_conflict_hi", SEL_CONF, 64'h1);
    nextCycle();
    pushExp("same_conflict_lo", SEL_CONF, 64'h0);

    // E-port bypass before the edge; debug still shows old value.
    wr_en = 1'b1; dstE = 4'd5; valE = 64'h55; srcA = 4'd5; dbg_idx = 4'd5;
    pushExp("bypE_valA", SEL_A, 64'h55);
    pushExp("bypE_dbg_old", SEL_DBG, 64'h0);
    nextCycle();
    idle();
    pushExp("bypE_dbg_new", SEL_DBG, 64'h55);
    nextCycle();

    // Stalled writeback: nothing forwarded, nothing committed, no conflict.
    wr_en = 1'b0; dstE = 4'd6; valE = 64'hFF; dstM = 4'd6; valM = 64'hEE;
    srcB = 4'd6; dbg_idx = 4'd6;
    pushExp("stall_valB_old", SEL_B, 64'h0);
    nextCycle();
    idle();
    pushExp("stall_r6_unchanged", SEL_DBG, 64'h0);
    pushExp("stall_no_conflict", SEL_CONF, 64'h0);
    nextCycle();

    // Full-width value stored verbatim; RNONE reads zero and is never bypassed.
    wr_en = 1'b1; dstM = 4'd14; valM = 64'hDEAD_BEEF_CAFE_F00D;
    dstE = RNONE; valE = 64'h77; srcA = RNONE; dbg_idx = RNONE;
    pushExp("rnone_valA", SEL_A, 64'h0);
    pushExp("rnone_dbg", SEL_DBG, 64'h0);
    nextCycle();
    idle(); srcB = 4'd14; dbg_idx = 4'd14;
    pushExp("wide_valB_r14", SEL_B, 64'hDEAD_BEEF_CAFE_F00D);
    pushExp("wide_dbg_r14", SEL_DBG, 64'hDEAD_BEEF_CAFE_F00D);
    nextCycle();

    // Mid-cycle asynchronous reset clears written registers immediately.
    srcA = 4'd1; srcB = 4'd2; dbg_idx = 4'd3;
    #1 reset = 1'b1;
    pushExp("async_rst_r1", SEL_A, 64'h0);
    pushExp("async_rst_r2", SEL_B, 64'h0);
    pushExp("async_rst_r3", SEL_DBG, 64'h0);
    nextCycle();
    srcA = 4'd4; srcB = RNONE; dbg_idx = 4'd14;
    pushExp("async_rst_sp", SEL_A, SPV);
    pushExp("async_rst_rnone", SEL_B, 64'h0);
    pushExp("async_rst_r14", SEL_DBG, 64'h0);
    pushExp("async_rst_conflict", SEL_CONF, 64'h0);
    nextCycle();
    reset = 1'b0;

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 Parameter XLEN, default 64, data width of every register and value port.
REQ-002 Parameter AW, default 4, register-index width; 2^AW-1 architectural registers exist.
REQ-003 Parameter RNONE, default 4'hF (all ones), index meaning "no register".
REQ-004 Parameter SP_IDX, default 4, index of the stack pointer.
REQ-005 Parameter SP_INIT, default 64'h0, reset value of register SP_IDX.
REQ-006 clock  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 srcA  input  AW  decode read index A.
REQ-009 srcB  input  AW  decode read index B.
REQ-010 valA  output  XLEN  combinational read data A.
REQ-011 valB  output  XLEN  combinational read data B.
REQ-012 wr_en  input  1  writeback stage valid; low for bubble or stall.
REQ-013 dstE  input  AW  E-port write index.
REQ-014 valE  input  XLEN  E-port write data.
REQ-015 dstM  input  AW  M-port write index.
REQ-016 valM  input  XLEN  M-port write data.
REQ-017 dbg_idx  input  AW  debug read index.
REQ-018 dbg_val  output  XLEN  combinational debug read data, no bypass.
REQ-019 wr_conflict  output  1  registered pulse: last cycle had dstE == dstM != RNONE with wr_en.

Function
REQ-020 Storage: 2^AW-1 registers of XLEN bits; no storage at index RNONE.
REQ-021 Write: on rising clock with wr_en=1, dstE != RNONE writes valE; dstM != RNONE writes valM; both ports same cycle to different indices both commit.
REQ-022 Same-index dual write: valM commits, valE discarded (popq %rsp semantics); wr_conflict=1 the following cycle for exactly one cycle.
REQ-023 wr_en=0: no register changes, wr_conflict next cycle 0.
REQ-024 Read of RNONE on srcA/srcB/dbg_idx: returns zero.
REQ-025 Bypass, per read port, priority order: wr_en && src==dstM && dstM!=RNONE -> valM; else wr_en && src==dstE && dstE!=RNONE -> valE; else stored value.
REQ-026 Read latency zero (combinational); write visible in stored value the cycle after the edge; bypass makes it visible in the same cycle.
REQ-027 dbg_val reads stored array only, never bypassed.
REQ-028 srcA == srcB: both outputs identical, same bypass rules.
REQ-029 Indices are unsigned; no wrap or arithmetic on data; values stored verbatim at XLEN.

Reset
REQ-030 reset assertion immediately (asynchronously) clears all registers to zero except SP_IDX, which loads SP_INIT.
REQ-031 reset clears wr_conflict to 0.
REQ-032 While reset high, writes ignored regardless of wr_en; reads return reset values (bypass still active, combinational).
REQ-033 Reset release mid-writeback: first write taken on first rising edge with reset low.

Structure
REQ-034 Shared package holds XLEN, AW, RNONE, SP_IDX and register-index constants (RAX..R14) for use by decode, execute and hazard logic.
REQ-035 One sub-module, regfile_bypass, implements the per-port bypass mux and is instantiated twice (A, B).

Verification
REQ-036 Reset with SP_INIT=64'h100, srcA=4, srcB=0 -> valA=64'h100, valB=0, dbg_val(idx 3)=0.
REQ-037 wr_en=1, dstE=2 valE=64'hAA, dstM=3 valM=64'hBB; next cycle dbg_idx=2 -> 64'hAA, dbg_idx=3 -> 64'hBB.
REQ-038 wr_en=1, dstE=4 valE=64'h10, dstM=4 valM=64'h20 -> reg 4 = 64'h20 next cycle, wr_conflict=1 for one cycle then 0.
REQ-039 Same cycle wr_en=1, dstE=5 valE=64'h55, srcA=5 -> valA=64'h55 before the edge, dbg_val(5) old value until edge.
REQ-040 wr_en=0, dstE=6 valE=64'hFF, srcB=6 -> valB old value, reg 6 unchanged after edge.
REQ-041 reset asserted mid-cycle after writes to regs 1..3 -> all read zero immediately, SP reads SP_INIT, srcA=RNONE -> 0.
